// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU sequencer: state encoding, default widths
// and the ALU opcode map used by the host protocol.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 6;

    // One-hot FSM encoding.
    localparam int ST_W = 6;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 6'b000001;
    localparam state_t ST_WAIT_B  = 6'b000010;
    localparam state_t ST_WAIT_OP = 6'b000100;
    localparam state_t ST_EXEC    = 6'b001000;
    localparam state_t ST_SEND    = 6'b010000;
    localparam state_t ST_WAIT_TX = 6'b100000;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_ctrl_edge_det.sv
// Rising-edge detector for level-style done flags: evt is high for the one clk
// where d is high and was low on the previous clk.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic evt
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d_q <= 1'b0;
        else
            d_q <= d;
    end

    assign evt = d & ~d_q;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: collects A, B and opcode bytes from the UART receiver, drives
// the ALU, and returns the result through the transmitter with a busy/err status.
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OP_W        = OP_W_DEF,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OP_W-1:0]   op_code,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic             rx_evt, tx_evt;
    logic [CNT_W-1:0] cnt;
    logic             timeout;

    logic ld_a, ld_b, ld_op, ld_tx;
    logic start_nxt, err_nxt, busy_set, busy_clr;
    logic cnt_clr, cnt_inc;

    edge_det u_rx_edge (
        .clk (clk),
        .rst (rst),
        .d   (rx_done),
        .evt (rx_evt)
    );

    edge_det u_tx_edge (
        .clk (clk),
        .rst (rst),
        .d   (tx_done),
        .evt (tx_evt)
    );

    // A byte arriving on the terminal cycle takes priority over the abort.
    assign timeout = (cnt == CNT_TERM) && !rx_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (rx_evt) state_nxt = ST_WAIT_B;
            ST_WAIT_B:  if (rx_evt) state_nxt = ST_WAIT_OP;
                        else if (timeout) state_nxt = ST_IDLE;
            ST_WAIT_OP: if (rx_evt) state_nxt = ST_EXEC;
                        else if (timeout) state_nxt = ST_IDLE;
            ST_EXEC:    state_nxt = ST_SEND;
            ST_SEND:    state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_evt) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        ld_tx     = 1'b0;
        start_nxt = 1'b0;
        err_nxt   = 1'b0;
        busy_set  = 1'b0;
        busy_clr  = 1'b0;
        cnt_clr   = rx_evt || (state == ST_IDLE);
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE:    ld_a = rx_evt;
            ST_WAIT_B: begin
                ld_b    = rx_evt;
                err_nxt = timeout;
                cnt_inc = !rx_evt && !timeout;
            end
            ST_WAIT_OP: begin
                ld_op    = rx_evt;
                busy_set = rx_evt;
                err_nxt  = timeout;
                cnt_inc  = !rx_evt && !timeout;
            end
            ST_EXEC: begin
                ld_tx     = 1'b1;
                start_nxt = 1'b1;
            end
            ST_WAIT_TX: busy_clr = tx_evt;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_code  <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            if (ld_a)  op_a    <= rx_data;
            if (ld_b)  op_b    <= rx_data;
            if (ld_op) op_code <= rx_data[OP_W-1:0];
            if (ld_tx) tx_data <= alu_res;
            tx_start <= start_nxt;
            err      <= err_nxt;
            if (busy_set)      busy <= 1'b1;
            else if (busy_clr) busy <= 1'b0;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: a long-timeout instance for the protocol
// tests and a 16-cycle-timeout instance for the abort/coincidence boundaries.
module tb_uart_alu_ctrl;
    import uart_pkg::*;

    localparam int TO   = 64;
    localparam int TO16 = 16;

    logic       clk = 1'b0;
    logic       rst, rx_done, tx_done;
    logic [7:0] rx_data;

    logic [7:0] alu_res, op_a, op_b, tx_data;
    logic [5:0] op_code;
    logic       tx_start, busy, err;

    logic [7:0] alu_res16, op_a16, op_b16, tx_data16;
    logic [5:0] op_code16;
    logic       tx_start16, busy16, err16;

    // Observation mux: which instance the tests are looking at.
    logic       sel16 = 1'b0;
    logic [7:0] m_op_a, m_op_b, m_tx_data;
    logic [5:0] m_op_code;
    logic       m_tx_start, m_busy, m_err;

    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0, start_cnt = 0, err_cnt = 0;
    logic [7:0] last_exp;

    logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRL:  return a >> b[2:0];
            OP_SRA:  return 8'($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res   = alu_fn(op_a, op_b, op_code);
    assign alu_res16 = alu_fn(op_a16, op_b16, op_code16);

    assign m_op_a     = sel16 ? op_a16     : op_a;
    assign m_op_b     = sel16 ? op_b16     : op_b;
    assign m_op_code  = sel16 ? op_code16  : op_code;
    assign m_tx_data  = sel16 ? tx_data16  : tx_data;
    assign m_tx_start = sel16 ? tx_start16 : tx_start;
    assign m_busy     = sel16 ? busy16     : busy;
    assign m_err      = sel16 ? err16      : err;

    uart_alu_ctrl #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .tx_done(tx_done),
        .alu_res(alu_res), .op_a(op_a), .op_b(op_b), .op_code(op_code),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .err(err)
    );

    uart_alu_ctrl #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYC(TO16)) dut16 (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .tx_done(tx_done),
        .alu_res(alu_res16), .op_a(op_a16), .op_b(op_b16), .op_code(op_code16),
        .tx_start(tx_start16), .tx_data(tx_data16), .busy(busy16), .err(err16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_tx_start) start_cnt++;
        if (m_err)      err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte; cap returns the cycle index of the edge that samples it.
    task automatic drive_byte(input logic [7:0] d, input int hold, output int cap);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        cap = cyc;
        repeat (hold - 1) tick();
        rx_done = 1'b0;
        tick();
    endtask

    // Sends the opcode byte and checks capture, the 2-cycle launch latency and the result.
    task automatic finish_op(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opbyte, input int hold);
        logic [7:0] exp;
        int         s0;
        exp = alu_fn(a, b, opbyte[5:0]);
        s0  = start_cnt;
        rx_data = opbyte;
        rx_done = 1'b1;
        tick();
        n_cmp++;
        if ({m_busy, m_op_a, m_op_b, m_op_code, m_tx_start} !== {1'b1, a, b, opbyte[5:0], 1'b0}) begin
            n_bad++;
            $display("FAIL %s capture: busy/a/b/op/start got %b/%h/%h/%h/%b want 1/%h/%h/%h/0",
                     name, m_busy, m_op_a, m_op_b, m_op_code, m_tx_start, a, b, opbyte[5:0]);
        end
        tick();
        n_cmp++;
        if ({m_tx_start, m_tx_data} !== {1'b1, exp}) begin
            n_bad++;
            $display("FAIL %s launch: tx_start/tx_data got %b/%h want 1/%h", name, m_tx_start, m_tx_data, exp);
        end
        tick();
        n_cmp++;
        if ({m_tx_start, m_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s after launch: tx_start/busy got %b/%b want 0/1", name, m_tx_start, m_busy);
        end
        if (hold > 3) repeat (hold - 3) tick();
        rx_done = 1'b0;
        tick();
        n_cmp++;
        if (start_cnt - s0 != 1) begin
            n_bad++;
            $display("FAIL %s start pulses: got %0d want 1", name, start_cnt - s0);
        end
        last_exp = exp;
    endtask

    // Completes a transmission and checks busy drops on the tx_done edge.
    task automatic tx_ack(input string name);
        n_cmp++;
        if ({m_busy, m_tx_data} !== {1'b1, last_exp}) begin
            n_bad++;
            $display("FAIL %s before ack: busy/tx_data got %b/%h want 1/%h", name, m_busy, m_tx_data, last_exp);
        end
        tx_done = 1'b1;
        tick();
        n_cmp++;
        if (m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ack: busy got %b want 0", name, m_busy);
        end
        tick();
        tx_done = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        rx_done = 1'b0;
        tx_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({m_op_a, m_op_b, m_op_code, m_tx_data, m_tx_start, m_busy, m_err} !== '0) begin
            n_bad++;
            $display("FAIL %s: a/b/op/tx/start/busy/err got %h/%h/%h/%h/%b/%b/%b want all 0",
                     name, m_op_a, m_op_b, m_op_code, m_tx_data, m_tx_start, m_busy, m_err);
        end
    endtask

    task automatic test_reset();
        int cap;
        rst = 1'b1;
        tx_done = 1'b0;
        rx_done = 1'b1;
        rx_data = 8'h5A;
        #12;
        check_zero("reset state");
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (m_op_a !== 8'h5A) begin
            n_bad++;
            $display("FAIL rx held through reset: op_a got %h want 5a", m_op_a);
        end
        rx_done = 1'b0;
        tick();
        drive_byte(8'h03, 1, cap);
        finish_op("reset release frame", 8'h5A, 8'h03, {2'b11, OP_ADD}, 1);
        tx_ack("reset release frame");
    endtask

    task automatic test_add();
        int cap;
        drive_byte(8'h05, 1, cap);
        drive_byte(8'h03, 1, cap);
        finish_op("add", 8'h05, 8'h03, 8'h20, 1);
        n_cmp++;
        if (m_tx_data !== 8'h08) begin
            n_bad++;
            $display("FAIL add result: tx_data got %h want 08", m_tx_data);
        end
        repeat (5) tick();
        tx_ack("add");
    endtask

    task automatic test_level_held();
        int cap;
        drive_byte(8'h0F, 50, cap);
        drive_byte(8'hF0, 50, cap);
        finish_op("level held", 8'h0F, 8'hF0, 8'h24, 50);
        n_cmp++;
        if (m_tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL level held result: tx_data got %h want 00", m_tx_data);
        end
        tx_ack("level held");
    endtask

    task automatic test_drop_while_busy();
        int cap, s0;
        drive_byte(8'h09, 1, cap);
        drive_byte(8'h04, 1, cap);
        finish_op("drop sub", 8'h09, 8'h04, 8'h22, 1);
        s0 = start_cnt;
        drive_byte(8'hAA, 2, cap);
        n_cmp++;
        if ({m_op_a, m_op_b, m_tx_data, m_busy} !== {8'h09, 8'h04, 8'h05, 1'b1} || start_cnt != s0) begin
            n_bad++;
            $display("FAIL drop while busy: a/b/tx/busy got %h/%h/%h/%b want 09/04/05/1", m_op_a, m_op_b, m_tx_data, m_busy);
        end
        tx_ack("drop sub");
        // A stray tx_done edge in IDLE must not disturb the next frame.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        drive_byte(8'h07, 1, cap);
        drive_byte(8'h01, 1, cap);
        finish_op("after drop", 8'h07, 8'h01, 8'h20, 1);
        tx_ack("after drop");
    endtask

    task automatic test_random();
        int         cap, e0, gap;
        logic [7:0] a, b, opbyte;
        e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            a      = 8'($urandom);
            b      = 8'($urandom);
            opbyte = {2'($urandom), ops[$urandom_range(0, 7)]};
            drive_byte(a, $urandom_range(1, 4), cap);
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            drive_byte(b, $urandom_range(1, 4), cap);
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            finish_op("random", a, b, opbyte, $urandom_range(1, 4));
            gap = $urandom_range(0, 5);
            repeat (gap) tick();
            tx_ack("random");
        end
        n_cmp++;
        if (err_cnt != e0) begin
            n_bad++;
            $display("FAIL random no err: err pulses got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cap;
        drive_byte(8'h77, 1, cap);
        drive_byte(8'h66, 1, cap);
        #3 rst = 1'b1;
        #1 check_zero("reset in WAIT_OP");
        #1 rst = 1'b0;
        tick();
        drive_byte(8'h12, 1, cap);
        drive_byte(8'h34, 1, cap);
        finish_op("pre reset WAIT_TX", 8'h12, 8'h34, 8'h20, 1);
        #3 rst = 1'b1;
        #1 check_zero("reset in WAIT_TX");
        #1 rst = 1'b0;
        tick();
        drive_byte(8'h01, 1, cap);
        drive_byte(8'h01, 1, cap);
        finish_op("after reset", 8'h01, 8'h01, 8'h20, 1);
        tx_ack("after reset");
    endtask

    task automatic test_timeout();
        int  cap, e0;
        bit  seen;
        pulse_reset();
        sel16 = 1'b1;
        e0 = err_cnt;
        drive_byte(8'h11, 1, cap);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = m_err;
        end
        n_cmp++;
        if (!seen || (cyc - cap) != TO16) begin
            n_bad++;
            $display("FAIL timeout err timing: seen %b after %0d clk want 1 after %0d clk", seen, cyc - cap, TO16);
        end
        tick();
        n_cmp++;
        if (m_err !== 1'b0 || err_cnt - e0 != 1) begin
            n_bad++;
            $display("FAIL timeout err width: err %b pulses %0d want 0 and 1", m_err, err_cnt - e0);
        end
        drive_byte(8'h02, 1, cap);
        drive_byte(8'h02, 1, cap);
        finish_op("after timeout", 8'h02, 8'h02, 8'h20, 1);
        tx_ack("after timeout");
    endtask

    task automatic test_coincident();
        int cap, e0;
        e0 = err_cnt;
        drive_byte(8'h33, 1, cap);
        repeat (TO16 - 2) tick();
        rx_data = 8'h44;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        n_cmp++;
        if ({m_err, m_op_b} !== {1'b0, 8'h44} || (cyc - cap) != TO16) begin
            n_bad++;
            $display("FAIL coincident edge: err/op_b got %b/%h at %0d clk want 0/44 at %0d clk",
                     m_err, m_op_b, cyc - cap, TO16);
        end
        tick();
        finish_op("coincident", 8'h33, 8'h44, {2'b00, OP_XOR}, 1);
        tx_ack("coincident");
        n_cmp++;
        if (err_cnt != e0) begin
            n_bad++;
            $display("FAIL coincident no err: err pulses got %0d want 0", err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_level_held();
        test_drop_while_busy();
        test_random();
        test_reset_mid_frame();
        test_timeout();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU, captures the result, and sends it back through the transmitter with a start/done handshake.
- Adds an inter-byte timeout and a busy indication so the host can recover from partial frames.

Parameters:
- DATA_W, 8, width of operands, result and UART data bytes.
- OP_W, 6, opcode width; taken from the low OP_W bits of the third byte.
- TIMEOUT_CYC, 1000000, clk cycles allowed between bytes of one frame before the frame is abandoned (must be >= 2).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_done  in  1  receiver byte-complete flag; may stay high for many clk cycles, so only its rising edge counts.
- rx_data  in  DATA_W  received byte; valid on the clk where the rx_done rising edge is detected.
- tx_done  in  1  transmitter stop-bit-complete flag; only its rising edge counts.
- alu_res  in  DATA_W  ALU combinational result.
- op_a  out  DATA_W  registered operand A to the ALU.
- op_b  out  DATA_W  registered operand B to the ALU.
- op_code  out  OP_W  registered opcode to the ALU.
- tx_start  out  1  one-cycle pulse that launches a transmission.
- tx_data  out  DATA_W  byte to transmit; stable from the tx_start cycle until the tx_done edge.
- busy  out  1  high from the opcode capture until the tx_done edge is seen.
- err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset (async, any state): state=IDLE, and all of op_a, op_b, op_code, tx_data, tx_start, busy, err and the timeout counter go to 0. Both edge-detect registers go to 0. An rx_done held high through reset release therefore produces one edge, which is accepted.
- Edge detect: rx_evt = rx_done & ~rx_done_q; tx_evt = tx_done & ~tx_done_q. Each _q register updates every clk.
- States and transitions:
  - IDLE: on rx_evt, op_a<=rx_data and go to WAIT_B.
  - WAIT_B: on rx_evt, op_b<=rx_data and go to WAIT_OP.
  - WAIT_OP: on rx_evt, op_code<=rx_data[OP_W-1:0], busy<=1, go to EXEC.
  - EXEC: one cycle for the ALU to settle; tx_data<=alu_res; go to SEND.
  - SEND: tx_start=1 for exactly this cycle; go to WAIT_TX.
  - WAIT_TX: on tx_evt, busy<=0 and go to IDLE.
- Latency: the opcode rx_evt is cycle N. EXEC is N+1, tx_data is valid at N+2, and tx_start is high during N+2.
- Timeout:
  - The counter clears on every rx_evt and in IDLE. It increments each clk in WAIT_B and WAIT_OP.
  - On reaching TIMEOUT_CYC-1 with no rx_evt in that cycle: err pulses for 1 cycle, state returns to IDLE, and op_a/op_b keep stale values, which are not used further.
  - If rx_evt and terminal count coincide, rx_evt wins: the byte is accepted and there is no err.
- Bytes received in EXEC, SEND or WAIT_TX are dropped. They are not queued and do not affect operands.
- A tx_evt outside WAIT_TX is ignored.
- op_a, op_b and op_code hold their values until overwritten, so the ALU inputs stay stable during transmission.
- Pure synchronous design except the reset. No combinational path from inputs to outputs; tx_start, busy and err are registered.

Decomposition:
- Shared package (uart_pkg): state encoding constants for IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX as one-hot localparams; DATA_W/OP_W defaults; opcode constants (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111).
- One natural sub-module, edge_det: a 1-bit registered rising-edge detector with async active-high reset. It is instantiated twice, for rx_done and tx_done.

Test Plan:
- Normal ADD: rx bytes 0x05, 0x03, 0x20 with alu_res model = A+B. Required: op_a=0x05, op_b=0x03, op_code=0x20, tx_start pulse 2 clk after the third rx edge, tx_data=0x08, busy high until the tx_done edge.
- Level-held rx_done: hold rx_done high for 50 clk per byte (0x0F, 0xF0, 0x24). Required: exactly 3 bytes consumed, tx_data=0x00 (AND), a single tx_start pulse.
- Timeout: TIMEOUT_CYC=16; send 0x11 then nothing. Required: err pulse exactly 16 clk after the rx edge (counter terminal), state IDLE; then 0x02, 0x02, 0x20 produces tx_data=0x04.
- Drop while busy: after opcode 0x22 (SUB, A=0x09, B=0x04), inject an rx edge with 0xAA before tx_done. Required: tx_data=0x05, operands unchanged, next frame starts cleanly with the following byte.
- Reset mid-frame: assert rst asynchronously in WAIT_OP and in WAIT_TX. Required: all outputs 0 immediately without waiting for a clk edge; the next full frame 0x01, 0x01, 0x20 yields tx_data=0x02.
- Coincident edge/timeout: rx edge on the terminal-count cycle. Required: byte accepted, no err pulse, state advances.
